alu: RTL and testbench
======================

# alu

Registered 16-bit integer ALU for the MISC-V datapath. It takes two 16-bit operands and a 3-bit operation code and produces a 16-bit result plus a zero flag. Both outputs are registered on the rising clock edge. Control logic reads the zero flag for branch decisions.

## Interface
- No parameters; data width fixed at 16 bits, opcode width fixed at 3 bits.
- Clocking (already decided): one clock; reset is synchronous and active-high.
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- FirstInput  input  16  operand A, two's complement.
- SecondInput  input  16  operand B, two's complement.
- ALUOp  input  3  operation select.
- OutputData  output  16  registered result.
- Zero  output  1  registered flag; 1 when the registered result equals 0x0000.

## Operation
ALUOp encoding (A = FirstInput, B = SecondInput):
- 0 ADD: A + B.
- 1 SUB: A − B.
- 2 SLT: 0x0001 if A < B (signed), else 0x0000.
- 3 OR: A | B.
- 4 AND: A & B.
- 5 XOR: A ^ B.
- 6 SLL: A << B[3:0]; zero fill.
- 7 SRA: A >>> B[3:0]; sign fill.

Arithmetic and flag rules:
- ADD and SUB are modulo 2^16; carry and overflow are discarded.
- No overflow or carry outputs. 0x7FFF + 1 = 0x8000. 0x8000 − 1 = 0x7FFF.
- Shift amount uses only B[3:0]; B[15:4] is ignored.
- Zero is computed from the same next-result value that is loaded into OutputData, so the two are always consistent.
- No invalid opcodes; all 8 encodings are defined.

## Timing
- One-cycle latency: inputs present before rising edge N appear on OutputData/Zero after edge N and hold until the next edge.
- Both outputs change only on a rising CLK edge, never combinationally.
- Reset high at an edge: OutputData ← 0x0000, Zero ← 1.
- Reset takes priority over any operation on the same edge.
- Reset mid-stream discards the operation sampled on that edge.
- First operation after reset deasserts is sampled on the next edge.
- Changing ALUOp and the operands on the same cycle is legal; the new operation result appears after the next edge.
- No handshake; a new operation is accepted every cycle.

## Structure
- Shared package alu_pkg:
  - opcode localparams ALU_ADD=3'd0, ALU_SUB=3'd1, ALU_SLT=3'd2, ALU_OR=3'd3, ALU_AND=3'd4, ALU_XOR=3'd5, ALU_SLL=3'd6, ALU_SRA=3'd7;
  - DATA_W=16.
- Combinational sub-module alu_addsub:
  - inputs A, B and a subtract control;
  - outputs the 16-bit sum/difference;
  - also provides signed less-than, computed from the sign bits of the difference and an internal overflow term.
- Top level:
  - alu_addsub instance;
  - logic-op and shift case mux;
  - zero detect;
  - output registers.

## Test plan
- Reset: assert Reset one edge with inputs arbitrary -> OutputData=0x0000, Zero=1; with ADD 0+0 after release -> 0x0000, Zero=1.
- ADD: 1+1 -> 0x0002, Z=0; 15+28 -> 0x002B; −13+4 -> 0xFFF7 (−9); −3+−5 -> 0xFFF8 (−8); 0x7FFF+1 -> 0x8000, Z=0.
- SUB: 1−1 -> 0x0000, Z=1; 15−28 -> 0xFFF3 (−13); −13−4 -> 0xFFEF (−17); 13−(−4) -> 0x0011; −3−(−5) -> 0x0002.
- OR/AND/XOR: OR 1|2 -> 0x0003; OR −15|4 -> 0xFFF5 (−11); OR 0|0 -> 0x0000, Z=1; AND 1&2 -> 0, Z=1; AND −15&4 -> 0, Z=1; AND −15&3 -> 0x0001; XOR 0xFFFF^0xFFFF -> 0, Z=1.
- SLT/shifts: SLT −1 vs 1 -> 0x0001; SLT 0x7FFF vs 0x8000 -> 0x0000; SLL 0x0001 by 0x0013 -> 0x0008; SRA 0x8000 by 15 -> 0xFFFF.
- Latency/priority: change inputs every cycle with a mixed opcode sequence -> each result appears exactly one edge later. Assert Reset in the middle of the sequence -> that edge yields 0x0000/Z=1 regardless of opcode.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the MISC-V datapath ALU: data/opcode widths, opcode
// encodings and a small zero-detect helper used by the top level.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 3;
    localparam int SHAMT_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_SLT = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_AND = 3'd4;
    localparam logic [OP_W-1:0] ALU_XOR = 3'd5;
    localparam logic [OP_W-1:0] ALU_SLL = 3'd6;
    localparam logic [OP_W-1:0] ALU_SRA = 3'd7;

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational 16-bit adder/subtractor with a signed less-than output that
// is only meaningful while subtracting (A - B).
module alu_addsub
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_lt
);

    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W-1:0] w_sum;
    logic              w_ovf;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_sum   = i_a + w_b_eff + {{(DATA_W-1){1'b0}}, i_sub};

    // Two's-complement overflow: same-signed addends giving a differently-signed sum.
    assign w_ovf = (i_a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                   (w_sum[DATA_W-1] != i_a[DATA_W-1]);

    assign o_sum = w_sum;
    assign o_lt  = w_sum[DATA_W-1] ^ w_ovf;

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU: one-cycle latency, result and zero flag loaded on the
// same edge from the same next-result value.
module alu
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] FirstInput,
    input  logic [DATA_W-1:0] SecondInput,
    input  logic [OP_W-1:0]   ALUOp,
    output logic [DATA_W-1:0] OutputData,
    output logic              Zero
);

    logic              w_sub;
    logic [DATA_W-1:0] w_sum;
    logic              w_lt;
    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic [DATA_W-1:0] r_data;
    logic              r_zero;

    // SLT reuses the subtractor so the less-than comes from A - B.
    assign w_sub   = (ALUOp == ALU_SUB) || (ALUOp == ALU_SLT);
    assign w_shamt = SecondInput[SHAMT_W-1:0];

    alu_addsub u_addsub (
        .i_a   (FirstInput),
        .i_b   (SecondInput),
        .i_sub (w_sub),
        .o_sum (w_sum),
        .o_lt  (w_lt)
    );

    // Next-result select across all eight opcodes.
    always_comb begin
        w_result = {DATA_W{1'b0}};
        case (ALUOp)
            ALU_ADD: w_result = w_sum;
            ALU_SUB: w_result = w_sum;
            ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, w_lt};
            ALU_OR:  w_result = FirstInput | SecondInput;
            ALU_AND: w_result = FirstInput & SecondInput;
            ALU_XOR: w_result = FirstInput ^ SecondInput;
            ALU_SLL: w_result = FirstInput << w_shamt;
            ALU_SRA: w_result = DATA_W'($signed(FirstInput) >>> w_shamt);
            default: w_result = {DATA_W{1'b0}};
        endcase
    end

    assign w_zero = is_zero(w_result);

    // Output registers; reset wins over any operation on the same edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_data <= 16'h0000;
            r_zero <= 1'b1;
        end else begin
            r_data <= w_result;
            r_zero <= w_zero;
        end
    end

    assign OutputData = r_data;
    assign Zero       = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/latency sequences
// and randomized operations against an integer-arithmetic reference model.
module tb_alu;

    logic        CLK;
    logic        Reset;
    logic [15:0] FirstInput;
    logic [15:0] SecondInput;
    logic [2:0]  ALUOp;
    logic [15:0] OutputData;
    logic        Zero;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .FirstInput  (FirstInput),
        .SecondInput (SecondInput),
        .ALUOp       (ALUOp),
        .OutputData  (OutputData),
        .Zero        (Zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: plain signed integer arithmetic, truncated to 16 bits.
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int sa;
        int sb;
        int sh;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[3:0]);
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = (sa < sb) ? 1 : 0;
            3'd3: r = int'(a | b);
            3'd4: r = int'(a & b);
            3'd5: r = int'(a ^ b);
            3'd6: r = int'(a) * (1 << sh);
            3'd7: r = sa >>> sh;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive one operation, clock it in, and check both outputs just after the edge.
    task automatic apply(input string name, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
        ALUOp       = op;
        FirstInput  = a;
        SecondInput = b;
        @(posedge CLK);
        #1;
        check16({name, " data"}, OutputData, exp);
        check1({name, " zero"}, Zero, (exp == 16'h0000));
    endtask

    function automatic void add_vec(input logic [2:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic [15:0] exp);
        vec_t v;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    logic [15:0] prev_exp;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        Reset       = 1'b1;
        ALUOp       = 3'd0;
        FirstInput  = 16'h1234;
        SecondInput = 16'h4321;

        // Directed table from the test plan, expected values written out by hand.
        add_vec(3'd0, 16'd1,     16'd1,     16'h0002);
        add_vec(3'd0, 16'd15,    16'd28,    16'h002B);
        add_vec(3'd0, 16'hFFF3,  16'd4,     16'hFFF7);
        add_vec(3'd0, 16'hFFFD,  16'hFFFB,  16'hFFF8);
        add_vec(3'd0, 16'h7FFF,  16'h0001,  16'h8000);
        add_vec(3'd1, 16'd1,     16'd1,     16'h0000);
        add_vec(3'd1, 16'd15,    16'd28,    16'hFFF3);
        add_vec(3'd1, 16'hFFF3,  16'd4,     16'hFFEF);
        add_vec(3'd1, 16'd13,    16'hFFFC,  16'h0011);
        add_vec(3'd1, 16'hFFFD,  16'hFFFB,  16'h0002);
        add_vec(3'd1, 16'h8000,  16'h0001,  16'h7FFF);
        add_vec(3'd3, 16'd1,     16'd2,     16'h0003);
        add_vec(3'd3, 16'hFFF1,  16'd4,     16'hFFF5);
        add_vec(3'd3, 16'd0,     16'd0,     16'h0000);
        add_vec(3'd4, 16'd1,     16'd2,     16'h0000);
        add_vec(3'd4, 16'hFFF1,  16'd4,     16'h0000);
        add_vec(3'd4, 16'hFFF1,  16'd3,     16'h0001);
        add_vec(3'd5, 16'hFFFF,  16'hFFFF,  16'h0000);
        add_vec(3'd5, 16'hA5A5,  16'h0FF0,  16'hAA55);
        add_vec(3'd2, 16'hFFFF,  16'h0001,  16'h0001);
        add_vec(3'd2, 16'h7FFF,  16'h8000,  16'h0000);
        add_vec(3'd2, 16'h8000,  16'h7FFF,  16'h0001);
        add_vec(3'd2, 16'h0005,  16'h0005,  16'h0000);
        add_vec(3'd6, 16'h0001,  16'h0013,  16'h0008);
        add_vec(3'd6, 16'h00FF,  16'hFFF8,  16'hFF00);
        add_vec(3'd7, 16'h8000,  16'd15,    16'hFFFF);
        add_vec(3'd7, 16'h4000,  16'd14,    16'h0001);
        add_vec(3'd7, 16'hF0F0,  16'h0024,  16'hFF0F);

        // Reset held over two edges with arbitrary inputs.
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check16("reset data", OutputData, 16'h0000);
        check1("reset zero", Zero, 1'b1);

        Reset = 1'b0;
        apply("add 0+0 after reset", 3'd0, 16'h0000, 16'h0000, 16'h0000);

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a,
                  vecs[i].b, vecs[i].exp);
        end

        // Mixed sequence: outputs hold until the edge, then show exactly this cycle's op.
        prev_exp = ref_alu(vecs[vecs.size()-1].op, vecs[vecs.size()-1].a, vecs[vecs.size()-1].b);
        for (int k = 0; k < 16; k++) begin
            r_op = 3'(k % 8);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            ALUOp       = r_op;
            FirstInput  = r_a;
            SecondInput = r_b;
            #3;
            check16($sformatf("seq%0d hold", k), OutputData, prev_exp);
            if (k == 9) begin
                Reset = 1'b1;
                @(posedge CLK);
                #1;
                check16("seq mid reset data", OutputData, 16'h0000);
                check1("seq mid reset zero", Zero, 1'b1);
                Reset    = 1'b0;
                prev_exp = 16'h0000;
            end else begin
                @(posedge CLK);
                #1;
                prev_exp = ref_alu(r_op, r_a, r_b);
                check16($sformatf("seq%0d data", k), OutputData, prev_exp);
                check1($sformatf("seq%0d zero", k), Zero, (prev_exp == 16'h0000));
            end
        end

        // Randomized operations, with some operands biased towards boundaries.
        for (int k = 0; k < 300; k++) begin
            r_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: r_a = 16'h8000;
                1: r_a = 16'h7FFF;
                default: r_a = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: r_b = r_a;
                1: r_b = 16'hFFFF;
                default: r_b = 16'($urandom);
            endcase
            apply($sformatf("rand%0d op%0d", k, r_op), r_op, r_a, r_b, ref_alu(r_op, r_a, r_b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
